// File: rtl/spi_slave.sv
// SPI responder with RX/TX FIFOs behind a 4-word Avalon-MM aperture; SPI inputs oversampled in clk.
// Optional interrupt output enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave #(
    parameter int N = 16,
    parameter int M = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [3:0]  byteenable,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(M);
    localparam logic [2:0] SYNC_RST = 3'b100;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // Index 0 = sclk, 1 = mosi, 2 = ss_n. Stage 2 is the synced value, stage 3 its previous copy.
    logic [2:0] spi_in;
    logic [2:0] sync_cur;
    logic [2:0] sync_prev;
    assign spi_in = {ss_n, mosi, sclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : sync_g
            logic [3:0] stage_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= {4{SYNC_RST[gi]}};
                end else begin
                    stage_reg <= {stage_reg[2:0], spi_in[gi]};
                end
            end
            assign sync_cur[gi]  = stage_reg[2];
            assign sync_prev[gi] = stage_reg[3];
        end
    endgenerate

    logic sclk_rise, sclk_fall, ss_s, ss_fall, mosi_s;
    assign sclk_rise = sync_cur[0] & ~sync_prev[0];
    assign sclk_fall = ~sync_cur[0] & sync_prev[0];
    assign mosi_s    = sync_cur[1];
    assign ss_s      = sync_cur[2];
    assign ss_fall   = ~sync_cur[2] & sync_prev[2];

    // Control and status registers
    logic [LW-1:0] len_reg;
    logic          cpha_reg, cpol_reg, en_reg;
    logic [2:0]    irq_mask_reg;
    logic          rxfo_reg, txfo_reg, txur_reg;
    logic          rd_prev_reg, wr_prev_reg;

    logic acc_rd, acc_wr, rd_first, wr_first;
    assign acc_rd   = read & chipselect;
    assign acc_wr   = write & chipselect;
    assign rd_first = acc_rd & ~rd_prev_reg;
    assign wr_first = acc_wr & ~wr_prev_reg;

    // FIFOs: index 0 = RX (SPI pushes, CPU pops), index 1 = TX (CPU pushes, SPI pops)
    logic          fifo_push  [2];
    logic          fifo_pop   [2];
    logic          fifo_empty [2];
    logic          fifo_full  [2];
    logic [M-1:0]  fifo_wdata [2];
    logic [M-1:0]  fifo_head  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : fifo_g
            logic [M-1:0]  mem [N];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem[wr_ptr_reg] <= fifo_wdata[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (fifo_push[gi] && !fifo_pop[gi]) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (!fifo_push[gi] && fifo_pop[gi]) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
            end

            assign fifo_head[gi]  = mem[rd_ptr_reg];
            assign fifo_empty[gi] = (cnt_reg == '0);
            assign fifo_full[gi]  = (cnt_reg == CW'(N));
        end
    endgenerate

    // Shift engine
    state_t         state_reg;
    logic [LW:0]    bitcnt_reg;
    logic [M-1:0]   rx_sh_reg, tx_sh_reg;
    logic           miso_reg;

    logic           leading, trailing, sample_edge, shift_edge, abort;
    logic           load_go, last_sample, shift_ok;
    logic [LW:0]    len_p1, bitcnt_m1;
    logic [M-1:0]   rx_next, word_mask, tx_load;

    assign leading     = cpol_reg ? sclk_fall : sclk_rise;
    assign trailing    = cpol_reg ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_reg ? trailing : leading;
    assign shift_edge  = cpha_reg ? leading : trailing;
    assign abort       = !en_reg || ss_s;
    assign len_p1      = {1'b0, len_reg} + 1'b1;
    assign bitcnt_m1   = bitcnt_reg - 1'b1;
    assign rx_next     = {rx_sh_reg[M-2:0], mosi_s};
    assign word_mask   = ~(({M{1'b1}} << len_reg) << 1);
    assign tx_load     = fifo_empty[1] ? '0 : fifo_head[1];

    assign load_go     = (state_reg == LOAD) && !abort;
    assign last_sample = (state_reg == SHIFT) && !abort && sample_edge && (bitcnt_reg == 1);
    // With CPHA=0 the trailing edge that follows a word's last sample arrives after the next
    // LOAD; it belongs to the previous word and must not disturb the freshly loaded MSB.
    assign shift_ok    = (state_reg == SHIFT) && !abort && shift_edge &&
                         (cpha_reg || bitcnt_reg != len_p1);

    logic rx_push_req, tx_push_req, rxfo_set, txfo_set, txur_set;
    assign rx_push_req   = last_sample;
    assign fifo_pop[0]   = rd_first && (address == 2'b00) && !fifo_empty[0];
    assign fifo_push[0]  = rx_push_req && (!fifo_full[0] || fifo_pop[0]);
    assign fifo_wdata[0] = rx_next & word_mask;
    assign rxfo_set      = rx_push_req && fifo_full[0] && !fifo_pop[0];

    assign tx_push_req   = wr_first && (address == 2'b00);
    assign fifo_pop[1]   = load_go && !fifo_empty[1];
    assign fifo_push[1]  = tx_push_req && (!fifo_full[1] || fifo_pop[1]);
    assign fifo_wdata[1] = M'(writedata);
    assign txfo_set      = tx_push_req && fifo_full[1] && !fifo_pop[1];
    assign txur_set      = load_go && fifo_empty[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            bitcnt_reg <= '0;
            rx_sh_reg  <= '0;
            tx_sh_reg  <= '0;
            miso_reg   <= 1'b0;
        end else if (abort) begin
            state_reg  <= IDLE;
            bitcnt_reg <= '0;
            miso_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    miso_reg   <= 1'b0;
                    bitcnt_reg <= '0;
                    if (ss_fall) state_reg <= LOAD;
                end
                LOAD: begin
                    tx_sh_reg  <= tx_load;
                    bitcnt_reg <= len_p1;
                    if (!cpha_reg) miso_reg <= tx_load[len_reg];
                    state_reg  <= SHIFT;
                end
                SHIFT: begin
                    if (shift_ok) miso_reg <= tx_sh_reg[bitcnt_m1[LW-1:0]];
                    if (sample_edge) begin
                        rx_sh_reg  <= rx_next;
                        bitcnt_reg <= bitcnt_m1;
                        if (bitcnt_reg == 1) state_reg <= LOAD;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign miso = miso_reg;

    logic status_wr;
    assign status_wr = acc_wr && (address == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg      <= '0;
            cpha_reg     <= 1'b0;
            cpol_reg     <= 1'b0;
            en_reg       <= 1'b0;
            irq_mask_reg <= '0;
            rxfo_reg     <= 1'b0;
            txfo_reg     <= 1'b0;
            txur_reg     <= 1'b0;
            rd_prev_reg  <= 1'b0;
            wr_prev_reg  <= 1'b0;
        end else begin
            rd_prev_reg <= acc_rd;
            wr_prev_reg <= acc_wr;
            if (acc_wr && address == 2'b10) begin
                len_reg  <= writedata[LW-1:0];
                cpha_reg <= writedata[5];
                cpol_reg <= writedata[6];
                en_reg   <= writedata[15];
`ifdef SPI_SLAVE_IRQ_EN
                irq_mask_reg <= writedata[9:7];
`endif
            end
            // A set in the same cycle as a clear wins
            rxfo_reg <= rxfo_set | (rxfo_reg & ~(status_wr & writedata[2]));
            txfo_reg <= txfo_set | (txfo_reg & ~(status_wr & writedata[5]));
            txur_reg <= txur_set | (txur_reg & ~(status_wr & writedata[6]));
        end
    end

    logic [7:0] status;
    assign status = {~ss_s, txur_reg, txfo_reg, fifo_full[1], fifo_empty[1],
                     rxfo_reg, fifo_full[0], fifo_empty[0]};

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(irq_mask_reg & {fifo_empty[1], rxfo_reg, ~fifo_empty[0]});
        end
    end
    assign irq = irq_reg;
`endif

    always_comb begin
        readdata = '0;
        if (acc_rd) begin
            case (address)
                2'b00:   readdata = fifo_empty[0] ? 32'd0 : 32'(fifo_head[0]);
                2'b01:   readdata = {24'd0, status};
                2'b10:   readdata = {16'd0, en_reg, 5'd0, irq_mask_reg, cpol_reg, cpha_reg, len_reg};
                default: readdata = '0;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{byteenable, writedata, sync_prev[1], bitcnt_m1[LW]};

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: CPU aperture tasks plus a bit-banged SPI master.
module tb_spi_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic [3:0]  byteenable = 4'hF;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        miso;
`ifdef SPI_SLAVE_IRQ_EN
    logic        irq;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    logic cpol_v = 1'b0;
    logic cpha_v = 1'b0;

    spi_slave dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss_n       (ss_n),
        .miso       (miso)
`ifdef SPI_SLAVE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1; chipselect = 1'b1;
        #1 d = readdata;
        @(negedge clk);
        read = 1'b0; chipselect = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(a, d);
        check(tag, d, exp);
        $display("read  %s addr=%0d data=%h", tag, a, d);
    endtask

    task automatic ss_begin();
        @(negedge clk);
        sclk = cpol_v;
        repeat (6) @(negedge clk);
        ss_n = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic ss_end();
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Sends dout[nbits-1:0] MSB first; din collects miso at each master sample point
    task automatic spi_bits(input int nbits, input logic [31:0] dout, output logic [31:0] din);
        din = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha_v) begin
                mosi = dout[i];
                repeat (HALF) @(negedge clk);
                din = {din[30:0], miso};
                sclk = ~cpol_v;
                repeat (HALF) @(negedge clk);
                sclk = cpol_v;
            end else begin
                sclk = ~cpol_v;
                mosi = dout[i];
                repeat (HALF) @(negedge clk);
                din = {din[30:0], miso};
                sclk = cpol_v;
                repeat (HALF) @(negedge clk);
            end
        end
        $display("spi   sent=%h miso=%h bits=%0d", dout, din, nbits);
    endtask

    initial begin
        logic [31:0] d0, d1;
        logic [31:0] exp_ctrl;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_readdata_idle", readdata, 32'h0);
        check("reset_miso", {31'd0, miso}, 32'h0);
        read_check("reset_status", 2'b01, 32'h09);
        read_check("reset_control", 2'b10, 32'h0);

`ifdef SPI_SLAVE_IRQ_EN
        exp_ctrl = 32'h8387;
`else
        exp_ctrl = 32'h8007;
`endif
        cpu_write(2'b10, 32'h8387);
        read_check("ctrl_mask_bits", 2'b10, exp_ctrl);

        // Mode 0, 8-bit: TX 0xA5, master sends 0x3C
        cpu_write(2'b10, 32'h8007);
        read_check("ctrl_mode0", 2'b10, 32'h8007);
        cpu_write(2'b00, 32'hA5);
        read_check("status_tx_loaded", 2'b01, 32'h01);
        cpol_v = 1'b0; cpha_v = 1'b0;
        ss_begin();
        spi_bits(8, 32'h3C, d0);
        ss_end();
        check("mode0_miso", d0, 32'hA5);
        read_check("mode0_status", 2'b01, 32'h48);
        read_check("mode0_rx", 2'b00, 32'h3C);
        cpu_write(2'b01, 32'h40);
        read_check("mode0_status_clr", 2'b01, 32'h09);

        // Mode 3, 32-bit, two back-to-back words in one frame
        cpu_write(2'b10, 32'h807F);
        cpu_write(2'b00, 32'h12345678);
        cpu_write(2'b00, 32'hCAFEF00D);
        cpol_v = 1'b1; cpha_v = 1'b1;
        ss_begin();
        spi_bits(32, 32'hDEADBEEF, d0);
        spi_bits(32, 32'h0BADC0DE, d1);
        ss_end();
        check("mode3_miso_w0", d0, 32'h12345678);
        check("mode3_miso_w1", d1, 32'hCAFEF00D);
        read_check("mode3_rx_w0", 2'b00, 32'hDEADBEEF);
        read_check("mode3_rx_w1", 2'b00, 32'h0BADC0DE);
        read_check("mode3_status", 2'b01, 32'h49);
        cpu_write(2'b01, 32'h40);

        // TX empty at frame start: miso stays 0, underrun flagged then cleared
        cpu_write(2'b10, 32'h8007);
        cpol_v = 1'b0; cpha_v = 1'b0;
        ss_begin();
        spi_bits(8, 32'h81, d0);
        ss_end();
        check("txur_miso", d0, 32'h0);
        read_check("txur_status", 2'b01, 32'h48);
        cpu_write(2'b01, 32'h40);
        read_check("txur_cleared", 2'b01, 32'h08);
        read_check("txur_rx", 2'b00, 32'h81);

        // RX overflow: 17 words with no CPU reads
        ss_begin();
        for (int i = 0; i < 17; i++) begin
            spi_bits(8, 32'(i + 1), d0);
        end
        ss_end();
        read_check("rx_ovf_status", 2'b01, 32'h4E);
        for (int i = 0; i < 16; i++) begin
            read_check("rx_ovf_data", 2'b00, 32'(i + 1));
        end
        read_check("rx_drained_status", 2'b01, 32'h4D);
        read_check("rx_empty_data", 2'b00, 32'h0);
        read_check("reserved_read", 2'b11, 32'h0);
        cpu_write(2'b01, 32'h44);
        read_check("flags_cleared", 2'b01, 32'h09);

        // Partial word aborted by ss_n rise, next word intact
        ss_begin();
        read_check("busy_status", 2'b01, 32'hC9);
        spi_bits(5, 32'h1F, d0);
        ss_end();
        read_check("partial_no_push", 2'b01, 32'h49);
        ss_begin();
        spi_bits(8, 32'h5A, d0);
        ss_end();
        read_check("after_partial_rx", 2'b00, 32'h5A);
        cpu_write(2'b01, 32'h40);

`ifdef SPI_SLAVE_IRQ_EN
        // Interrupt on RX not empty
        cpu_write(2'b10, 32'h8087);
        @(negedge clk);
        check("irq_idle", {31'd0, irq}, 32'h0);
        ss_begin();
        spi_bits(8, 32'h77, d0);
        ss_end();
        check("irq_set", {31'd0, irq}, 32'h1);
        read_check("irq_rx", 2'b00, 32'h77);
        @(posedge clk);
        #1 check("irq_clear", {31'd0, irq}, 32'h0);
        cpu_write(2'b01, 32'h40);
        cpu_write(2'b10, 32'h8007);
`endif

        // TX overflow, then reset flushes everything
        for (int i = 0; i < 16; i++) begin
            cpu_write(2'b00, 32'(i));
        end
        read_check("tx_full_status", 2'b01, 32'h11);
        cpu_write(2'b00, 32'hFF);
        read_check("tx_ovf_status", 2'b01, 32'h31);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        read_check("post_reset_status", 2'b01, 32'h09);
        read_check("post_reset_control", 2'b10, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
